// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: PPC-side writes/reads, registers exported to user logic.
// Ports: OPB_* bus inputs, Sl_* slave responses, user_data_out/user_wr_strb to user logic.
// Optional macro OPB_REGBANK_SHADOW_EN: bus side uses shadows, index NUM_REGS commits.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01014900,
  parameter logic [31:0] C_HIGHADDR   = 32'h010149FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter int          NUM_REGS     = 4,
  parameter logic [31:0] RESET_VALUE  = 32'h0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:31]              OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:31]              OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:31]              Sl_DBus,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic                     Sl_xferAck,
  output logic [NUM_REGS*32-1:0]   user_data_out,
  output logic [NUM_REGS-1:0]      user_wr_strb
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RECOVER
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0] addr;
  logic [31:0] offs;
  logic [31:0] idx;
  logic [3:0]  be_v;
  logic [31:0] mask;
  logic [31:0] wdata;
  logic        in_range;
  logic        hit;
  logic        take;
  logic        wr;
  logic        reg_sel;
  logic        held_q;
  logic [31:0] rd_v;
  logic [31:0] rd_q;
  logic [NUM_REGS-1:0] strb_q;
  logic [31:0] bus_q [NUM_REGS];

  assign addr     = OPB_ABus;
  assign offs     = addr - C_BASEADDR;
  assign idx      = offs >> 2;
  assign in_range = OPB_select
                    && (addr >= C_BASEADDR)
                    && (addr <= C_HIGHADDR);
  // held_q stops a select still held after its ack from starting
  // a second transfer once RECOVER has passed.
  assign hit      = in_range && !held_q;
  assign take     = (state_q == IDLE) && hit;
  assign be_v     = OPB_BE;
  assign wr       = take && !OPB_RNW && (|be_v);
  assign reg_sel  = idx < 32'(NUM_REGS);
  assign wdata    = OPB_DBus;
  // be_v[3] is OPB_BE[0], which owns the most significant byte.
  assign mask     = {{8{be_v[3]}}, {8{be_v[2]}},
                     {8{be_v[1]}}, {8{be_v[0]}}};

`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0] out_q [NUM_REGS];
  logic        commit;
  assign commit = wr && (idx == 32'(NUM_REGS));
`endif

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_sel && idx == 32'(i)) rd_v = bus_q[i];
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bus_q[i] <= RESET_VALUE;
`ifdef OPB_REGBANK_SHADOW_EN
        out_q[i] <= RESET_VALUE;
`endif
      end
      strb_q <= '0;
      rd_q   <= '0;
      held_q <= 1'b0;
    end else begin
      strb_q <= '0;
      rd_q   <= (take && OPB_RNW) ? rd_v : '0;
      if (!OPB_select) held_q <= 1'b0;
      else if (take)   held_q <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr && reg_sel && idx == 32'(i)) begin
          bus_q[i] <= (bus_q[i] & ~mask) | (wdata & mask);
`ifndef OPB_REGBANK_SHADOW_EN
          strb_q[i] <= 1'b1;
`endif
        end
      end
`ifdef OPB_REGBANK_SHADOW_EN
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          out_q[i] <= bus_q[i];
        end
        strb_q <= '1;
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
`ifdef OPB_REGBANK_SHADOW_EN
    assign user_data_out[32*g +: 32] = out_q[g];
`else
    assign user_data_out[32*g +: 32] = bus_q[g];
`endif
  end

  assign Sl_xferAck   = (state_q == ACK);
  assign Sl_DBus      = Sl_xferAck ? rd_q : 32'h0;
  assign Sl_errAck    = 1'b0;
  assign Sl_retry     = 1'b0;
  assign Sl_toutSup   = 1'b0;
  assign user_wr_strb = strb_q;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, C_OPB_AWIDTH,
                       C_OPB_DWIDTH, C_FAMILY, offs[1:0]};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink.
// Directed and $urandom transfers against an array-based bank model.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01014900;
  localparam logic [31:0] HIGH = 32'h010149FF;
  localparam int          N    = 4;
  localparam logic [31:0] RV   = 32'h0;
`ifdef OPB_REGBANK_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [0:31]       abus;
  logic [0:3]        be;
  logic [0:31]       dbus;
  logic              rnw;
  logic              sel;
  logic              seq;
  logic [0:31]       sl_dbus;
  logic              sl_err;
  logic              sl_retry;
  logic              sl_tout;
  logic              sl_ack;
  logic [N*32-1:0]   udo;
  logic [N-1:0]      strb;

  logic [31:0] m_out [N];
  logic [31:0] m_sh  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_errAck     (sl_err),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_tout),
    .Sl_xferAck    (sl_ack),
    .user_data_out (udo),
    .user_wr_strb  (strb)
  );

  task automatic check(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [0:3]  b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (b[k]) r[31-8*k -: 8] = d[31-8*k -: 8];
    return r;
  endfunction

  function automatic logic [511:0] udo_model();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[32*i +: 32] = m_out[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_out[i] = RV;
      m_sh[i]  = RV;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack"},  sl_ack,  1'b0);
    check({tag, "_dbus"}, sl_dbus, 32'h0);
    check({tag, "_strb"}, strb,    '0);
    check({tag, "_udo"},  udo,     udo_model());
  endtask

  // One transfer; select is sampled on `hold` clock edges.
  task automatic xfer(input string       tag,
                      input logic [31:0] a,
                      input bit          r,
                      input logic [0:3]  b,
                      input logic [31:0] d,
                      input int          hold);
    bit          hit;
    longint      idx;
    logic [31:0] exp_rd;
    logic [N-1:0] exp_strb;
    hit      = (a >= BASE) && (a <= HIGH);
    idx      = longint'((a - BASE) >> 2);
    exp_rd   = '0;
    exp_strb = '0;
    if (hit) begin
      if (r) begin
        if (idx < N) exp_rd = SH ? m_sh[idx] : m_out[idx];
      end else if (b != 4'b0000) begin
        if (idx < N) begin
          if (SH) m_sh[idx] = merge(m_sh[idx], d, b);
          else begin
            m_out[idx] = merge(m_out[idx], d, b);
            exp_strb[idx] = 1'b1;
          end
        end else if (SH && idx == N) begin
          for (int i = 0; i < N; i++) m_out[i] = m_sh[i];
          exp_strb = '1;
        end
      end
    end
    @(posedge clk); #1;
    abus = a; rnw = r; be = b; dbus = d;
    sel = 1'b1; seq = $urandom_range(0, 1);
    for (int c = 1; c <= hold + 2; c++) begin
      @(posedge clk); #1;
      if (c == hold) sel = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_ack"},  sl_ack,  hit);
        check({tag, "_dbus"}, sl_dbus, exp_rd);
        check({tag, "_strb"}, strb,    exp_strb);
        check({tag, "_udo"},  udo,     udo_model());
      end else begin
        check_quiet(tag);
      end
    end
  endtask

  task automatic reset_in_ack(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    abus = a; rnw = 1'b0; be = 4'b1111; dbus = d; sel = 1'b1;
    @(posedge clk); #1;
    check("rst_pre_ack", sl_ack, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0;
    model_reset();
    check_quiet("rst_in_ack");
    @(negedge clk);
    check_quiet("rst_after");
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    rst = 1'b1; abus = '0; be = '0; dbus = '0;
    rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    check("tie_err", {sl_err, sl_retry, sl_tout}, 3'b000);

    xfer("wr_dead",  BASE + 8, 1'b0, 4'b1111, 32'hDEADBEEF, 1);
`ifndef OPB_REGBANK_SHADOW_EN
    check("dead_reg", udo[95:64], 32'hDEADBEEF);
`endif
    xfer("wr_be0100", BASE + 8, 1'b0, 4'b0100, 32'h11223344, 1);
`ifndef OPB_REGBANK_SHADOW_EN
    check("merge_reg", udo[95:64], 32'hDE22BEEF);
`endif
    xfer("rd_merge", BASE + 8, 1'b1, 4'b1111, 32'h0, 1);
    xfer("rd_hold5", BASE + 8, 1'b1, 4'b1111, 32'h0, 5);
    xfer("wr_be0",   BASE + 4, 1'b0, 4'b0000, 32'hFFFFFFFF, 1);
    xfer("rd_idx7",  BASE + 28, 1'b1, 4'b1111, 32'h0, 1);
    xfer("wr_idx7",  BASE + 28, 1'b0, 4'b1111, 32'h12345678, 1);
    xfer("miss_hi",  HIGH + 4, 1'b0, 4'b1111, 32'hA5A5A5A5, 2);
    xfer("miss_lo",  BASE - 4, 1'b1, 4'b1111, 32'h0, 2);

    xfer("sh_w0", BASE + 0, 1'b0, 4'b1111, 32'hCAFE0000, 1);
    xfer("sh_w1", BASE + 4, 1'b0, 4'b1111, 32'h0000F00D, 1);
    xfer("commit", BASE + 4*N, 1'b0, 4'b1111, 32'h1, 1);
    xfer("rd_commit", BASE + 4*N, 1'b1, 4'b1111, 32'h0, 1);

    reset_in_ack(BASE + 12, 32'h87654321);
    xfer("post_rst", BASE + 12, 1'b1, 4'b1111, 32'h0, 1);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = HIGH + 1 + $urandom_range(0, 255);
      else if (r == 1) a = BASE - 1 - $urandom_range(0, 15);
      else a = BASE + 4 * $urandom_range(0, N + 2)
               + $urandom_range(0, 3);
      xfer("rand", a, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom,
           $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got stuck want finish");
    $fatal(1);
  end

endmodule
